// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and state enum for the lfsr8 seed path
package lfsr_pkg;

  // Width of the lfsr8 state register and of every seed byte
  localparam int STATE_W = 8;

  // Seed used when a string folds to all-zero (an all-zero LFSR state locks up)
  localparam logic [STATE_W-1:0] FALLBACK_SEED_DEFAULT = 8'h01;

  // Seed loader control states
  typedef enum logic {
    ACCUM = 1'b0,
    LOAD  = 1'b1
  } state_t;

endpackage

// File: rtl/seed_fold.sv
// rtl/seed_fold.sv - one fold step of a character into the seed accumulator (SEED_LOADER_ROTATE_EN selects rotate-xor)
module seed_fold
  import lfsr_pkg::*;
(
  input  logic [STATE_W-1:0] acc,
  input  logic [STATE_W-1:0] data,
  output logic [STATE_W-1:0] next_acc
);

`ifdef SEED_LOADER_ROTATE_EN
  // Rotating before the xor makes the seed depend on character order
  assign next_acc = {acc[STATE_W-2:0], acc[STATE_W-1]} ^ data;
`else
  // Plain xor: the seed depends only on the multiset of characters
  assign next_acc = acc ^ data;
`endif

endmodule

// File: rtl/seed_loader.sv
// rtl/seed_loader.sv - folds a character stream into an lfsr8 seed and pulses load_seed (SEED_LOADER_ROTATE_EN selects rotate-xor fold)
module seed_loader
  import lfsr_pkg::*;
#(
  parameter int                 MAX_LEN       = 32,
  parameter logic [STATE_W-1:0] FALLBACK_SEED = FALLBACK_SEED_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [STATE_W-1:0]             in_data,
  input  logic                           in_last,
  output logic [STATE_W-1:0]             seed,
  output logic                           load_seed,
  output logic [$clog2(MAX_LEN+1)-1:0]   char_count,
  output logic                           overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);

  state_t             state;
  logic [STATE_W-1:0] acc;
  // Set after a completed string: the next accepted byte starts a fresh fold,
  // while the visible results of the previous string stay untouched until then.
  logic               fresh;

  logic               take;
  logic               full;
  logic               counted;
  logic [STATE_W-1:0] acc_base;
  logic [STATE_W-1:0] folded;
  logic [STATE_W-1:0] acc_next;
  logic [CW-1:0]      cnt_base;
  logic               ovf_base;

  assign in_ready = (state == ACCUM) && !rst;
  assign take     = in_valid && in_ready;

  assign acc_base = fresh ? '0   : acc;
  assign cnt_base = fresh ? '0   : char_count;
  assign ovf_base = fresh ? 1'b0 : overflow;

  assign full     = (cnt_base == CW'(MAX_LEN));
  assign counted  = (in_data != '0) && !full;

  seed_fold u_fold (
    .acc      (acc_base),
    .data     (in_data),
    .next_acc (folded)
  );

  assign acc_next = counted ? folded : acc_base;

  // Control FSM: accumulate characters, then spend one cycle presenting the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc        <= '0;
      fresh      <= 1'b0;
      seed       <= FALLBACK_SEED;
      load_seed  <= 1'b0;
      char_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          load_seed <= 1'b0;
          if (take) begin
            acc        <= acc_next;
            char_count <= counted ? cnt_base + CW'(1) : cnt_base;
            overflow   <= ovf_base | ((in_data != '0) && full);
            fresh      <= in_last;
            if (in_last) begin
              seed      <= (acc_next == '0) ? FALLBACK_SEED : acc_next;
              load_seed <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          load_seed <= 1'b0;
          state     <= ACCUM;
        end
        default: begin
          load_seed <= 1'b0;
          state     <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seed_loader.sv
// tb/tb_seed_loader.sv - self-checking bench for seed_loader
module tb_seed_loader;
  import lfsr_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [7:0]    seed;
  logic          load_seed;
  logic [CW-1:0] char_count;
  logic          overflow;

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  logic prev_load = 1'b0;

  typedef struct {
    string      txt;
    bit         fixed;
    logic [7:0] exp_seed;
    int         exp_cnt;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl[4];

  seed_loader #(.MAX_LEN(MAX_LEN), .FALLBACK_SEED(8'h01)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .seed       (seed),
    .load_seed  (load_seed),
    .char_count (char_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counter and back-to-back pulse detector
  always @(negedge clk) begin
    if (load_seed) begin
      pulses++;
      total++;
      if (prev_load) begin
        bad++;
        $display("FAIL load_seed_twice: got 2 consecutive pulses expected 1");
      end
    end
    prev_load = load_seed;
  end

  // Reference: fold the string by the character rules, then substitute the fallback
  function automatic void model(input logic [7:0] q[$], output logic [7:0] s,
                                output int c, output bit o);
    logic [7:0] a;
    a = 8'h00; c = 0; o = 1'b0;
    foreach (q[i]) begin
      if (q[i] != 8'h00) begin
        if (c == MAX_LEN) o = 1'b1;
        else begin
`ifdef SEED_LOADER_ROTATE_EN
          a = {a[6:0], a[7]} ^ q[i];
`else
          a = a ^ q[i];
`endif
          c++;
        end
      end
    end
    s = (a == 8'h00) ? 8'h01 : a;
  endfunction

  function automatic void to_q(input string t, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
  endfunction

  // Drive a string byte by byte; with last, check the LOAD cycle against the model
  task automatic send(input logic [7:0] q[$], input bit with_last, input bit gaps,
                      input bit keep_valid, input string name);
    logic [7:0] es;
    int         ec;
    bit         eo;
    int         budget;
    model(q, es, ec, eo);
    foreach (q[i]) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = with_last && (i == q.size() - 1);
      #1;
      budget = 0;
      while (!in_ready && budget < 10) begin
        @(negedge clk);
        #1;
        budget++;
      end
      if (!in_ready) begin
        chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (!keep_valid || !with_last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (!with_last) return;
    #1;
    chk({name, "_load"}, load_seed, 1);
    chk({name, "_ready_in_load"}, in_ready, 0);
    chk({name, "_seed"}, seed, es);
    chk({name, "_cnt"}, char_count, ec);
    chk({name, "_ovf"}, overflow, eo);
    if (!keep_valid) begin
      @(negedge clk);
      #1;
      chk({name, "_load_after"}, load_seed, 0);
      chk({name, "_seed_hold"}, seed, es);
      chk({name, "_cnt_hold"}, char_count, ec);
      chk({name, "_ovf_hold"}, overflow, eo);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int         p0;

    tbl[0] = '{"Tintareanu", 1'b1, 8'h2B, 10, 1'b0};
    tbl[1] = '{"AA",         1'b1, 8'h01, 2,  1'b0};
    tbl[2] = '{"Z",          1'b1, 8'h5A, 1,  1'b0};
`ifdef SEED_LOADER_ROTATE_EN
    tbl[0].fixed = 1'b0;
    tbl[3] = '{"AB",         1'b1, 8'hC0, 2,  1'b0};
`else
    tbl[3] = '{"AB",         1'b1, 8'h03, 2,  1'b0};
`endif

    // Reset state and in_ready held low during reset
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seed", seed, 8'h01);
    chk("rst_load", load_seed, 0);
    chk("rst_cnt", char_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready_after", in_ready, 1);
    @(negedge clk);

    // Table of named strings
    for (int v = 0; v < 4; v++) begin
      to_q(tbl[v].txt, q);
      send(q, 1'b1, 1'b0, 1'b0, tbl[v].txt);
      if (tbl[v].fixed) begin
        chk({tbl[v].txt, "_seed_const"}, seed, tbl[v].exp_seed);
        chk({tbl[v].txt, "_cnt_const"}, char_count, tbl[v].exp_cnt);
        chk({tbl[v].txt, "_ovf_const"}, overflow, tbl[v].exp_ovf);
      end
    end

    // NUL bytes are consumed but not counted
    q = '{8'h00, 8'h00, 8'h5A};
    send(q, 1'b1, 1'b0, 1'b0, "nul");
    chk("nul_seed_const", seed, 8'h5A);
    chk("nul_cnt_const", char_count, 1);

    // 33 characters: one past the limit
    q = {};
    for (int i = 0; i < 33; i++) q.push_back(8'h61);
    send(q, 1'b1, 1'b0, 1'b0, "sat");
    chk("sat_seed_const", seed, 8'h01);
    chk("sat_cnt_const", char_count, 32);
    chk("sat_ovf_const", overflow, 1);

    // Reset in the middle of a string aborts it without a pulse
    to_q("Ti", q);
    send(q, 1'b0, 1'b0, 1'b0, "abort");
    p0 = pulses;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_no_pulse", pulses, p0);
    chk("abort_cnt", char_count, 0);
    chk("abort_seed", seed, 8'h01);
    @(negedge clk);
    to_q("Z", q);
    send(q, 1'b1, 1'b0, 1'b0, "after_abort");
    chk("after_abort_seed", seed, 8'h5A);
    chk("after_abort_pulses", pulses, p0 + 1);

    // Back-to-back strings with in_valid held high across LOAD
    to_q("AB", q);
    send(q, 1'b1, 1'b0, 1'b1, "b2b_a");
    to_q("Tintareanu", q);
    send(q, 1'b1, 1'b0, 1'b1, "b2b_b");
    to_q("xyz", q);
    send(q, 1'b1, 1'b0, 1'b0, "b2b_c");

    // Random strings with NULs, idle gaps and back-to-back boundaries
    for (int n = 0; n < 30; n++) begin
      int len;
      len = $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send(q, 1'b1, 1'b1, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seed_loader.md
SEED_LOADER -- requirements
Module: seed_loader

Interface
REQ-001 Parameter MAX_LEN, default 32: maximum counted non-NUL characters per string.
REQ-002 Parameter FALLBACK_SEED, default 8'h01: seed substituted when the fold result is 8'h00.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock shared with lfsr8.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  character byte present on in_data.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 in_data  input  8  ASCII character.
REQ-009 in_last  input  1  final byte of the string; qualified by in_valid.
REQ-010 seed  output  8  folded seed; connects to lfsr8 seed.
REQ-011 load_seed  output  1  one-cycle pulse; connects to lfsr8 load_seed.
REQ-012 char_count  output  $clog2(MAX_LEN+1)  non-NUL characters counted in the current or last string.
REQ-013 overflow  output  1  more than MAX_LEN non-NUL characters seen in the string.

Function
REQ-014 States: ACCUM and LOAD; reset state is ACCUM.
REQ-015 ACCUM: in_ready=1; a byte is accepted when in_valid && in_ready.
REQ-016 Accepted byte 8'h00 SHALL be consumed without changing the accumulator or char_count.
REQ-017 Accepted non-NUL byte with char_count<MAX_LEN: acc <= acc ^ in_data; char_count increments.
REQ-018 Accepted non-NUL byte with char_count==MAX_LEN: byte discarded, overflow <= 1, char_count saturates.
REQ-019 Accepted byte with in_last=1: fold includes that byte (REQ-016..018 apply); the next state is LOAD.
REQ-020 seed SHALL be registered at the in_last handshake edge as the final fold, or FALLBACK_SEED if the fold is 8'h00.
REQ-021 LOAD lasts exactly one cycle: load_seed=1, in_ready=0; the next state is ACCUM.
REQ-022 Latency: load_seed is high in the cycle immediately following the in_last handshake cycle.
REQ-023 seed, char_count and overflow SHALL hold stable from the LOAD cycle until the first accepted byte of the next string.
REQ-024 At that first accepted byte, the accumulator, char_count and overflow restart from zero before folding.
REQ-025 in_valid asserted during LOAD is not accepted; the source holds its data (valid/ready rule).
REQ-026 load_seed SHALL never be high in two consecutive cycles.

Reset
REQ-027 rst=1 at a clock edge: state ACCUM, acc=0, seed=FALLBACK_SEED, load_seed=0, char_count=0, overflow=0.
REQ-028 Reset during a string or in LOAD aborts it; no load_seed pulse is issued for the aborted string.
REQ-029 in_ready SHALL be 0 while rst=1.

Configuration
REQ-030 Macro SEED_LOADER_ROTATE_EN defined: fold is acc <= {acc[6:0],acc[7]} ^ in_data (order-sensitive).
REQ-031 Macro undefined: fold is a plain XOR per REQ-017 (order-insensitive); no rotate logic is synthesised.

Structure
REQ-032 A shared package lfsr_pkg SHALL hold the 8-bit state width constant, the FALLBACK_SEED default and the state-enum typedef (ACCUM, LOAD).
REQ-033 One sub-module, seed_fold (combinational: acc, byte -> next acc, honouring SEED_LOADER_ROTATE_EN), SHALL be instantiated; the FSM stays in seed_loader.

Verification
REQ-034 Stream "Tintareanu", last on 'u', macro off -> load_seed is 1 cycle after the last byte; seed=8'h2B; char_count=10; overflow=0.
REQ-035 Stream "AA", macro off -> seed=8'h01 (fallback); char_count=2.
REQ-036 Stream 8'h00,8'h00,last 8'h5A -> seed=8'h5A; char_count=1.
REQ-037 Stream of 33 'a' bytes, last on the 33rd -> seed=8'h01; char_count=32; overflow=1.
REQ-038 Stream "AB": macro off -> seed=8'h03; macro on -> seed=8'hC0.
REQ-039 rst pulsed after "Ti" and before last, then "Z" with last -> exactly one load_seed pulse with seed=8'h5A; back-to-back strings with in_valid held high -> in_ready=0 in LOAD and no byte lost.
